nh_window_gen: RTL and testbench
================================

// Module: nh_window_gen
// PURPOSE
//  Parametrised sliding-window (neighbourhood) generator for the convolution datapath.
//  Accepts a raster-ordered pixel stream, buffers NH_DIM-1 image lines internally, and
//  presents a full NH_DIM x NH_DIM window each time a window lies entirely inside the image.
//  Sits between the pixel input stage and the multiply-accumulate array; adds frame
//  tracking (row/col counters, sof resync, frame_done) and optional stride-2 decimation.
// PARAMETERS
//  DATA_W  8  pixel bit width
//  NH_DIM  3  window edge length; legal range >= 2
//  IMG_W   32 pixels per image line; legal range >= NH_DIM
//  IMG_H   32 lines per frame; legal range >= NH_DIM
// PORTS
//  clock       in   1                     rising-edge clock
//  reset       in   1                     asynchronous, active-low reset
//  in_valid    in   1                     shift_in carries a pixel this cycle
//  sof         in   1                     qualified by in_valid: this pixel is (row 0, col 0)
//  shift_in    in   DATA_W                pixel data, raster order
//  dval        out  1                     current_nh holds a valid window (1-cycle pulse)
//  frame_done  out  1                     pulse: last pixel of the frame has been absorbed
//  current_nh  out  DATA_W*NH_DIM*NH_DIM  window; element (r,c) at [(r*NH_DIM+c)*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Reset: dval=0, frame_done=0, current_nh=0, row=col=0, window regs and line buffers = 0.
//  - State advances only on in_valid=1. With in_valid=0, all state holds and dval=frame_done=0.
//  - No backpressure: every in_valid pixel is accepted.
//  - Counters: col 0..IMG_W-1, wraps to 0 and increments row. Row 0..IMG_H-1, wraps to 0.
//  - sof=1 with in_valid: this pixel is (0,0) regardless of counter state, and the counters
//    continue from there. Stale window/line contents are never exposed, because dval is gated.
//  - Window: r=0 is the oldest (top) row, c=0 is the oldest (left) column. A pixel accepted at
//    (row,col) becomes element (NH_DIM-1,NH_DIM-1).
//  - Line buffers: NH_DIM-1 chained line delays sized so that element (r,c) equals the pixel at
//    (row-NH_DIM+1+r, col-NH_DIM+1+c).
//  - dval: registered. It is asserted the cycle after accepting (row,col) when
//    row>=NH_DIM-1 and col>=NH_DIM-1. Latency is 1 cycle; current_nh updates in the same cycle.
//  - current_nh holds its value while dval=0. It is valid only when dval=1.
//  - frame_done: asserted the cycle after accepting (IMG_H-1,IMG_W-1), coincident with the last
//    dval. If sof arrives before that, the interrupted frame produces no frame_done.
//  - Line wrap: windows never straddle lines. Columns < NH_DIM-1 produce no dval.
//  - Asynchronous reset mid-frame: everything clears immediately, and the next pixel is (0,0).
//  - Counter widths: $clog2(IMG_W) and $clog2(IMG_H) bits, with 1-bit minimum.
// CONFIGURATION
//  NH_WINDOW_STRIDE2_EN defined:
//    - dval (and its window) is suppressed unless (row-NH_DIM+1) and (col-NH_DIM+1) are both
//      even, i.e. stride 2 on the window's top-left corner.
//    - frame_done timing is unchanged.
//    - Line buffering and counters are identical.
//  NH_WINDOW_STRIDE2_EN undefined: stride 1, every in-image window is emitted.
// TESTING (DATA_W=8, NH_DIM=3, IMG_W=8, IMG_H=6, pixel(r,c)=r*16+c)
//  1. Continuous frame, sof on first pixel -> first dval 1 cycle after 0x22 is accepted, with
//     current_nh = {22,21,20,12,11,10,02,01,00} (MSB..LSB). Exactly 24 dvals. Last window has
//     (2,2)=0x57. frame_done pulses once, with that last dval.
//  2. Same frame, in_valid randomly low ~40% of cycles -> identical 24 windows in order; no
//     dval on any cycle following an in_valid=0 cycle.
//  3. sof reasserted at the pixel that would be (3,4) -> no dval until the new (2,2) is
//     accepted. The next window is the correct 3x3 of the new frame. No frame_done for the
//     aborted frame.
//  4. reset low mid-frame at (4,5) -> dval/frame_done/current_nh = 0 immediately. A fresh frame
//     then yields test 1 results exactly.
//  5. Two back-to-back frames, no idle cycles -> 48 dvals and 2 frame_done pulses. The second
//     frame's first window = {22,21,20,12,11,10,02,01,00} (no frame-1 data).
//  6. NH_WINDOW_STRIDE2_EN defined, test 1 stimulus -> exactly 6 dvals, with bottom-right
//     pixels 0x22,0x24,0x26,0x42,0x44,0x46. frame_done unchanged.

Source files
------------

// File: rtl/nh_window_gen.sv
// ============================================================================
// Module   : nh_window_gen
// Purpose  : Sliding NH_DIM x NH_DIM window generator over a raster pixel stream.
//            Optional stride-2 decimation when NH_WINDOW_STRIDE2_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nh_window_gen #(
  parameter int DATA_W = 8,
  parameter int NH_DIM = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic                              sof,
  input  logic [DATA_W-1:0]                 shift_in,
  output logic                              dval,
  output logic                              frame_done,
  output logic [DATA_W*NH_DIM*NH_DIM-1:0]   current_nh
);

  localparam int c_col_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_row_w = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(IMG_W - 1);
  localparam logic [c_row_w-1:0] c_row_last  = c_row_w'(IMG_H - 1);
  localparam logic [c_col_w-1:0] c_col_first = c_col_w'(NH_DIM - 1);
  localparam logic [c_row_w-1:0] c_row_first = c_row_w'(NH_DIM - 1);
`ifdef NH_WINDOW_STRIDE2_EN
  localparam logic c_par = 1'((NH_DIM - 1) % 2);
`endif

  logic [c_col_w-1:0] r_col, w_col, w_col_nxt;
  logic [c_row_w-1:0] r_row, w_row, w_row_nxt;
  logic               w_last_col, w_last_row, w_in_win, w_emit;
  logic               r_dval, r_fd;

  // r_hist keeps the newest NH_DIM-1 columns; the incoming column completes the window
  logic [DATA_W-1:0] r_hist    [NH_DIM][NH_DIM-1];
  logic [DATA_W-1:0] r_nh      [NH_DIM][NH_DIM];
  logic [DATA_W-1:0] w_win_nxt [NH_DIM][NH_DIM];
  logic [DATA_W-1:0] r_line    [NH_DIM-1][IMG_W];
  logic [DATA_W-1:0] w_line_in [NH_DIM-1];
  logic [DATA_W-1:0] w_head    [NH_DIM];

  // sof forces the current pixel to (0,0) irrespective of the counters
  always_comb begin
    w_col      = sof ? '0 : r_col;
    w_row      = sof ? '0 : r_row;
    w_last_col = (w_col == c_col_last);
    w_last_row = (w_row == c_row_last);
    w_col_nxt  = w_last_col ? '0 : w_col + c_col_w'(1);
    w_row_nxt  = w_last_col ? (w_last_row ? '0 : w_row + c_row_w'(1)) : w_row;
    w_in_win   = (w_row >= c_row_first) && (w_col >= c_col_first);
`ifdef NH_WINDOW_STRIDE2_EN
    w_emit     = w_in_win && (w_row[0] == c_par) && (w_col[0] == c_par);
`else
    w_emit     = w_in_win;
`endif
  end

  for (genvar r = 0; r < NH_DIM; r++) begin : g_head
    if (r == NH_DIM - 1) begin : g_top
      assign w_head[r] = shift_in;
    end else begin : g_buf
      assign w_head[r] = r_line[NH_DIM-2-r][IMG_W-1];
    end
  end

  for (genvar k = 0; k < NH_DIM - 1; k++) begin : g_line
    if (k == 0) begin : g_first
      assign w_line_in[k] = shift_in;
    end else begin : g_chain
      assign w_line_in[k] = r_line[k-1][IMG_W-1];
    end
  end

  always_comb begin
    for (int r = 0; r < NH_DIM; r++) begin
      for (int c = 0; c < NH_DIM - 1; c++) begin
        w_win_nxt[r][c] = r_hist[r][c];
      end
      w_win_nxt[r][NH_DIM-1] = w_head[r];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row  <= '0;
      r_col  <= '0;
      r_dval <= 1'b0;
      r_fd   <= 1'b0;
      for (int r = 0; r < NH_DIM; r++) begin
        for (int c = 0; c < NH_DIM - 1; c++) r_hist[r][c] <= '0;
        for (int c = 0; c < NH_DIM; c++)     r_nh[r][c]   <= '0;
      end
      for (int k = 0; k < NH_DIM - 1; k++) begin
        for (int i = 0; i < IMG_W; i++) r_line[k][i] <= '0;
      end
    end else begin
      r_dval <= in_valid && w_emit;
      r_fd   <= in_valid && w_last_col && w_last_row;
      if (in_valid) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        for (int r = 0; r < NH_DIM; r++) begin
          for (int c = 0; c < NH_DIM - 1; c++) r_hist[r][c] <= w_win_nxt[r][c+1];
        end
        if (w_emit) r_nh <= w_win_nxt;
        for (int k = 0; k < NH_DIM - 1; k++) begin
          r_line[k][0] <= w_line_in[k];
          for (int i = 1; i < IMG_W; i++) r_line[k][i] <= r_line[k][i-1];
        end
      end
    end
  end

  assign dval       = r_dval;
  assign frame_done = r_fd;

  for (genvar r = 0; r < NH_DIM; r++) begin : g_out_r
    for (genvar c = 0; c < NH_DIM; c++) begin : g_out_c
      assign current_nh[(r*NH_DIM+c)*DATA_W +: DATA_W] = r_nh[r][c];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nh_window_gen.sv
// ============================================================================
// Module   : tb_nh_window_gen
// Purpose  : Self-checking bench for nh_window_gen against an image-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nh_window_gen;

  localparam int DW = 8, NH = 3, IW = 8, IH = 6;
  localparam int NHW = DW * NH * NH;
`ifdef NH_WINDOW_STRIDE2_EN
  localparam int WIN_PER_FRAME = 6;
  localparam logic [NHW-1:0] LAST_WIN = 72'h464544363534262524;
  localparam int ABORT_WINS = 3;
`else
  localparam int WIN_PER_FRAME = 24;
  localparam logic [NHW-1:0] LAST_WIN = 72'h575655474645373635;
  localparam int ABORT_WINS = 8;
`endif

  logic clock, reset, in_valid, sof;
  logic [DW-1:0]  shift_in;
  logic           dval, frame_done;
  logic [NHW-1:0] current_nh;

  nh_window_gen #(.DATA_W(DW), .NH_DIM(NH), .IMG_W(IW), .IMG_H(IH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .sof(sof), .shift_in(shift_in),
    .dval(dval), .frame_done(frame_done), .current_nh(current_nh));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass = 0, n_total = 0;
  int n_dval, n_fd;
  logic [NHW-1:0] win_log[$];

  // model: image indexed by position, position tracked from the raster rules
  logic [DW-1:0]  img [IH][IW];
  int             m_row, m_col;
  logic           exp_dval, exp_fd;
  logic [NHW-1:0] exp_nh;

  task automatic chk(input string name, input logic [NHW-1:0] act, input logic [NHW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0;
    exp_dval = 1'b0; exp_fd = 1'b0; exp_nh = '0;
  endtask

  task automatic check_outputs();
    chk("dval", NHW'(dval), NHW'(exp_dval));
    chk("frame_done", NHW'(frame_done), NHW'(exp_fd));
    if (exp_dval) chk("current_nh", current_nh, exp_nh);
    if (dval) begin n_dval++; win_log.push_back(current_nh); end
    if (frame_done) n_fd++;
  endtask

  task automatic cycle(input logic v, input logic s, input logic [DW-1:0] d);
    bit stride_ok;
    in_valid = v; sof = s; shift_in = d;
    exp_dval = 1'b0; exp_fd = 1'b0;
    if (v) begin
      if (s) begin m_row = 0; m_col = 0; end
      img[m_row][m_col] = d;
`ifdef NH_WINDOW_STRIDE2_EN
      stride_ok = ((m_row - (NH-1)) % 2 == 0) && ((m_col - (NH-1)) % 2 == 0);
`else
      stride_ok = 1'b1;
`endif
      if (m_row >= NH-1 && m_col >= NH-1 && stride_ok) begin
        exp_dval = 1'b1;
        for (int r = 0; r < NH; r++)
          for (int c = 0; c < NH; c++)
            exp_nh[(r*NH+c)*DW +: DW] = img[m_row-NH+1+r][m_col-NH+1+c];
      end
      exp_fd = (m_row == IH-1) && (m_col == IW-1);
      m_col++;
      if (m_col == IW) begin m_col = 0; m_row = (m_row + 1) % IH; end
    end
    @(posedge clock); #1;
    check_outputs();
  endtask

  task automatic send_pixels(input logic [DW-1:0] base, input int count, input int idle_pct);
    for (int i = 0; i < count; i++) begin
      for (int k = 0; k < 20 && $urandom_range(0, 99) < idle_pct; k++)
        cycle(1'b0, 1'b0, DW'($urandom));
      cycle(1'b1, i == 0, base + DW'((i / IW) * 16 + (i % IW)));
    end
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic phase_start();
    n_dval = 0; n_fd = 0; win_log.delete();
  endtask

  task automatic check_frame_basic(input string tag);
    chk({tag, "_dval_count"}, NHW'(n_dval), NHW'(WIN_PER_FRAME));
    chk({tag, "_fd_count"}, NHW'(n_fd), NHW'(1));
    if (win_log.size() == WIN_PER_FRAME) begin
      chk({tag, "_first_win"}, win_log[0], 72'h222120121110020100);
      chk({tag, "_last_win"}, win_log[WIN_PER_FRAME-1], LAST_WIN);
    end else begin
      n_total++;
      $display("FAIL %s_win_log: got %0d windows expected %0d", tag, win_log.size(), WIN_PER_FRAME);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; sof = 1'b0; shift_in = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_dval", NHW'(dval), '0);
    chk("reset_fd", NHW'(frame_done), '0);
    chk("reset_nh", current_nh, '0);
    reset = 1'b1;
    @(posedge clock); #1;

    // 1: continuous frame
    phase_start();
    send_pixels(8'h00, IW*IH, 0);
    check_frame_basic("t1");

    // 2: same frame with ~40% idle cycles
    phase_start();
    send_pixels(8'h00, IW*IH, 40);
    check_frame_basic("t2");

    // 3: sof at what would be (3,4), new frame offset by 0x80
    phase_start();
    for (int i = 0; i < 3*IW + 4; i++) cycle(1'b1, i == 0, DW'((i / IW) * 16 + (i % IW)));
    send_pixels(8'h80, IW*IH, 0);
    chk("t3_dval_count", NHW'(n_dval), NHW'(ABORT_WINS + WIN_PER_FRAME));
    chk("t3_fd_count", NHW'(n_fd), NHW'(1));
    if (win_log.size() > ABORT_WINS)
      chk("t3_resync_win", win_log[ABORT_WINS], 72'hA2A1A0929190828180);
    else begin
      n_total++;
      $display("FAIL t3_resync_win: got %0d windows expected more than %0d", win_log.size(), ABORT_WINS);
    end

    // 4: async reset mid-frame, after (4,4) was accepted
    phase_start();
    for (int i = 0; i < 4*IW + 5; i++) cycle(1'b1, i == 0, DW'((i / IW) * 16 + (i % IW)));
    in_valid = 1'b0; sof = 1'b0;
    chk("t4_dval_before_reset", NHW'(dval), NHW'(1));
    #2 reset = 1'b0;
    #1;
    chk("t4_reset_dval", NHW'(dval), '0);
    chk("t4_reset_fd", NHW'(frame_done), '0);
    chk("t4_reset_nh", current_nh, '0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    phase_start();
    send_pixels(8'h00, IW*IH, 0);
    check_frame_basic("t4");

    // 5: back-to-back frames, second frame offset by 0x80
    phase_start();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < IW*IH; i++)
        cycle(1'b1, i == 0, DW'(f * 8'h80 + (i / IW) * 16 + (i % IW)));
    cycle(1'b0, 1'b0, '0);
    chk("t5_dval_count", NHW'(n_dval), NHW'(2 * WIN_PER_FRAME));
    chk("t5_fd_count", NHW'(n_fd), NHW'(2));
    if (win_log.size() == 2 * WIN_PER_FRAME)
      chk("t5_frame2_first_win", win_log[WIN_PER_FRAME], 72'hA2A1A0929190828180);
    else begin
      n_total++;
      $display("FAIL t5_win_log: got %0d windows expected %0d", win_log.size(), 2 * WIN_PER_FRAME);
    end

    // 6: random data, random gaps, occasional sof
    for (int i = 0; i < 1500; i++) begin
      logic v;
      v = ($urandom_range(0, 99) < 70);
      cycle(v, v && ($urandom_range(0, 299) == 0), DW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
